// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM encoding and status-byte helper for the SPI flash responder.
package spi_flash_responder_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_BE   = 8'hC7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_DATA_OUT,
        ST_IGNORE
    } state_t;

    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        return {6'b0, wel, wip};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, with rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [2:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= {3{RST_VAL}};
        end else begin
            pipe <= {pipe[1:0], din};
        end
    end

    assign sync = pipe[1];
    assign rise = pipe[1] & ~pipe[2];
    assign fall = ~pipe[1] & pipe[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash command responder: decodes WREN/WRDI/RDSR/READ/SE/BE,
// keeps the WEL/WIP status bits and times erases with a down-counter.
//
// state       | meaning
// ST_IDLE     | cs_n high, waiting for select
// ST_OPCODE   | shifting in the first byte
// ST_ADDR     | collecting 3 address bytes (READ, SE)
// ST_DATA_OUT | driving status or read data on miso
// ST_IGNORE   | opcode known, further bits only counted
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int unsigned BE_CYCLES = 1000,
    parameter int unsigned SE_CYCLES = 200
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sck,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        cmd_valid,
    output logic [7:0]  cmd_op,
    output logic [23:0] cmd_addr,
    output logic        wip,
    output logic        wel
);

    logic        sck_level_unused;
    logic        sck_rise, sck_fall;
    logic        cs_s, cs_rise, cs_fall;
    logic [1:0]  mosi_pipe;
    logic        mosi_s;

    state_t      state, state_nxt;
    logic [6:0]  rx_shift;
    logic [2:0]  bit_cnt, byte_cnt;
    logic [7:0]  opcode;
    logic [23:0] addr;
    logic [7:0]  tx_shift;
    logic        miso_q;
    logic [31:0] busy_cnt;

    logic        shift_en, fall_en, byte_done;
    logic [7:0]  rx_byte, tx_byte, op_accept;
    logic        exact8, exact32;
    logic        exec_wren, exec_wrdi, exec_be, exec_se, read_start;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (sck),
        .sync (sck_level_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (cs_n),
        .sync (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mosi_pipe <= 2'b00;
        end else begin
            mosi_pipe <= {mosi_pipe[0], mosi};
        end
    end
    assign mosi_s = mosi_pipe[1];

    assign shift_en  = sck_rise & ~cs_s;
    assign fall_en   = sck_fall & ~cs_s;
    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = shift_en && (bit_cnt == 3'd7);
    assign tx_byte   = (opcode == OP_RDSR) ? status_byte(wel, wip) : addr[7:0];

    // While an erase runs only RDSR survives; anything else becomes a no-op opcode.
    assign op_accept = (wip && (rx_byte != OP_RDSR)) ? 8'h00 : rx_byte;

    assign exact8     = (byte_cnt == 3'd1) && (bit_cnt == 3'd0);
    assign exact32    = (byte_cnt == 3'd4) && (bit_cnt == 3'd0);
    assign exec_wren  = cs_rise && (opcode == OP_WREN) && exact8;
    assign exec_wrdi  = cs_rise && (opcode == OP_WRDI) && exact8;
    assign exec_be    = cs_rise && (opcode == OP_BE) && exact8 && wel;
    assign exec_se    = cs_rise && (opcode == OP_SE) && exact32 && wel;
    assign read_start = byte_done && (state == ST_ADDR) && (byte_cnt == 3'd3)
                        && (opcode == OP_READ);

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) state_nxt = ST_OPCODE;
                end
                ST_OPCODE: begin
                    if (byte_done) begin
                        case (op_accept)
                            OP_SE, OP_READ: state_nxt = ST_ADDR;
                            OP_RDSR:        state_nxt = ST_DATA_OUT;
                            default:        state_nxt = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (byte_done && (byte_cnt == 3'd3)) begin
                        state_nxt = (opcode == OP_READ) ? ST_DATA_OUT : ST_IGNORE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            opcode    <= '0;
            addr      <= '0;
            tx_shift  <= '0;
            miso_q    <= 1'b0;
            busy_cnt  <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_addr  <= '0;
            wip       <= 1'b0;
            wel       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_valid <= 1'b0;

            if (cs_fall) begin
                rx_shift <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                opcode   <= '0;
                addr     <= '0;
            end else if (shift_en) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                // Saturating byte count is enough to tell exact 8/32-bit frames apart.
                if (byte_done && (byte_cnt != 3'd7)) byte_cnt <= byte_cnt + 3'd1;
                if (byte_done && (state == ST_OPCODE)) opcode <= op_accept;
                if (byte_done && (state == ST_ADDR)) addr <= {addr[15:0], rx_byte};
            end

            if (fall_en) begin
                if (state == ST_DATA_OUT) begin
                    if (bit_cnt == 3'd0) begin
                        miso_q   <= tx_byte[7];
                        tx_shift <= {tx_byte[6:0], 1'b0};
                        if (opcode == OP_READ) addr <= addr + 24'd1;
                    end else begin
                        miso_q   <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end else begin
                    miso_q <= 1'b0;
                end
            end

            if (exec_wren || exec_wrdi || exec_be || exec_se) begin
                cmd_valid <= 1'b1;
                cmd_op    <= opcode;
                cmd_addr  <= exec_se ? addr : 24'd0;
            end else if (read_start) begin
                cmd_valid <= 1'b1;
                cmd_op    <= OP_READ;
                cmd_addr  <= {addr[15:0], rx_byte};
            end

            if (exec_wren) begin
                wel <= 1'b1;
            end else if (exec_wrdi || exec_be || exec_se) begin
                wel <= 1'b0;
            end

            // Busy timer: wip drops on the edge where the count hits zero.
            if (exec_be) begin
                busy_cnt <= BE_CYCLES;
                wip      <= (BE_CYCLES != 0);
            end else if (exec_se) begin
                busy_cnt <= SE_CYCLES;
                wip      <= (SE_CYCLES != 0);
            end else if (wip) begin
                busy_cnt <= busy_cnt - 32'd1;
                if (busy_cnt == 32'd1) wip <= 1'b0;
            end
        end
    end

    assign miso = miso_q & ~cs_s & (state == ST_DATA_OUT);

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter BE_CYCLES, default 1000: WIP busy duration in sys_clk cycles after a bulk erase (0xC7).
REQ-002 Parameter SE_CYCLES, default 200: WIP busy duration in sys_clk cycles after a sector erase (0xD8).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 sys_clk  input  1  system clock; all logic on its rising edge.
REQ-005 sys_rst  input  1  synchronous active-high reset.
REQ-006 sck  input  1  SPI clock from the initiator, asynchronous, at most sys_clk/8.
REQ-007 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-008 mosi  input  1  SPI serial data in, MSB first.
REQ-009 miso  output  1  SPI serial data out, MSB first.
REQ-010 cmd_valid  output  1  one-cycle pulse when a command is accepted for execution.
REQ-011 cmd_op  output  8  opcode of the accepted command; held until the next cmd_valid.
REQ-012 cmd_addr  output  24  address of the accepted command (0 for non-address commands); held.
REQ-013 wip  output  1  status bit 0: erase in progress.
REQ-014 wel  output  1  status bit 1: write enable latch.

Function
REQ-015 sck, cs_n and mosi are each synchronised by a 2-FF chain; sck edges are detected from the synchronised value (SPI mode 0).
REQ-016 On a synchronised sck rising edge with cs_n low, mosi is shifted into an 8-bit register and a 3-bit bit counter increments, wrapping 7->0 to complete a byte.
REQ-017 On a synchronised sck falling edge with cs_n low, miso shifts to the next bit of the current output byte; when the first bit of a byte is due, miso is loaded with that byte's bit 7.
REQ-018 FSM states: IDLE, OPCODE, ADDR, DATA_OUT, IGNORE.
REQ-019 IDLE -> OPCODE on the cs_n falling edge; bit and byte counters clear.
REQ-020 OPCODE, byte complete: 0x06, 0x04 or 0xC7 -> IGNORE (opcode latched); 0xD8 or 0x03 -> ADDR; 0x05 -> DATA_OUT; any other opcode -> IGNORE with no effect.
REQ-021 ADDR collects 3 bytes MSB first into a 24-bit address. After the third byte: 0x03 -> DATA_OUT; 0xD8 -> IGNORE.
REQ-022 DATA_OUT for 0x05: each byte = {6'b0, wel, wip}, re-sampled at each byte start.
REQ-023 DATA_OUT for 0x03: byte n = (addr + n)[7:0], with addr incrementing per byte and 24-bit wrap 0xFFFFFF->0x000000.
REQ-024 miso is 0 whenever cs_n is high or the state is not DATA_OUT.
REQ-025 Any state -> IDLE on the cs_n rising edge; commands are evaluated at that edge.
REQ-026 Execution rules at the cs_n rise:
- 0x06: sets wel.
- 0x04: clears wel.
- 0xC7: needs exactly 8 bits and wel=1.
- 0xD8: needs exactly 32 bits and wel=1.
- Both erases: clear wel, set wip, load the busy counter with BE_CYCLES or SE_CYCLES.
- Any extra or missing bit count: the command is discarded.
REQ-027 cmd_valid pulses one cycle after an executed 0x06, 0x04, 0xC7 or 0xD8. A 0x03 pulses at ADDR->DATA_OUT. A 0x05 never pulses.
REQ-028 While wip=1, every opcode except 0x05 is discarded with no cmd_valid.
REQ-029 The busy counter decrements each cycle while wip=1; wip clears in the cycle the counter reaches 0.
REQ-030 A cs_n rise mid-byte aborts the transaction: partial shift data is dropped; wel and wip are unchanged unless a command is executed per REQ-026.

Reset
REQ-031 sys_rst: FSM=IDLE, all counters and shift registers 0, miso=0, cmd_valid=0, cmd_op=0, cmd_addr=0, wip=0, wel=0.
REQ-032 sys_rst mid-transaction or mid-erase aborts everything; the synchronisers reset to the idle levels sck=0, cs_n=1, mosi=0.

Structure
REQ-033 A shared package holds the opcode constants (WREN 0x06, WRDI 0x04, RDSR 0x05, READ 0x03, SE 0xD8, BE 0xC7) and the FSM state encoding.
REQ-034 One sub-module, spi_sync_edge, provides the 2-FF synchroniser plus rise/fall detect; it is instantiated for sck and cs_n (sync only for mosi).

Verification
REQ-035 WREN then RDSR, 1 byte read -> miso byte 0x02; cmd_valid once with cmd_op=0x06.
REQ-036 WREN, then BE 8 bits -> cmd_op=0xC7, wip=1 for BE_CYCLES cycles; RDSR during erase returns 0x01, then 0x00 after completion.
REQ-037 BE without a prior WREN -> no cmd_valid, wip stays 0; BE with 9 bits after WREN -> discarded, wel stays 1.
REQ-038 READ addr 0xFFFFFE for 3 bytes -> miso 0xFE, 0xFF, 0x00; cmd_addr=0xFFFFFE.
REQ-039 WREN, SE addr 0x012345 -> cmd_addr=0x012345, wip for SE_CYCLES cycles; a WREN during busy is ignored (wel stays 0).
REQ-040 sys_rst asserted during an erase and during a READ -> all outputs at reset values next cycle; a following RDSR returns 0x00.
